// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle between the bus masters and the round-robin arbiter.
// The master modport is the requester view; the slave modport is the arbiter view.
interface bus_arbiter_if #(
  parameter int width      = 8,
  parameter int indexWidth = 3
);
  logic [width-1:0]      request;
  logic [width-1:0]      grant;
  logic [indexWidth-1:0] grantIndex;
  logic                  busy;
  logic                  preempted;

  modport master (
    output request,
    input  grant,
    input  grantIndex,
    input  busy,
    input  preempted
  );

  modport slave (
    input  request,
    output grant,
    output grantIndex,
    output busy,
    output preempted
  );
endinterface

// File: rtl/bus_arbiter.sv
// Registered round-robin arbiter for the shared system bus: grants are held for a whole
// transaction, priority rotates on every release, and an optional hold limit preempts hogs.
module bus_arbiter #(
  parameter int width      = 8,
  parameter int indexWidth = 3,
  parameter int maxHold    = 0
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    GAP
  } state_t;

  localparam bit                    HoldEnabled = (maxHold != 0);
  localparam logic [15:0]           HoldLast    = 16'(maxHold - 1);
  localparam logic [indexWidth-1:0] LastIndex   = indexWidth'(width - 1);

  state_t                r_state, w_nextState;
  logic [width-1:0]      r_grant, w_nextGrant;
  logic [indexWidth-1:0] r_index, w_nextIndex;
  logic [indexWidth-1:0] r_ptr, w_nextPtr;
  logic [15:0]           r_cnt, w_nextCnt;
  logic                  r_busy;
  logic                  r_preempted, w_nextPreempted;

  logic                  w_pickValid;
  logic [indexWidth-1:0] w_pickIndex;
  logic                  w_grantedReq;
  logic                  w_othersPending;
  logic [indexWidth-1:0] w_succIndex;

  // Scan downward so the last hit written is the first requester at or after the pointer.
  always_comb begin
    w_pickValid = 1'b0;
    w_pickIndex = '0;
    for (int k = width - 1; k >= 0; k--) begin
      logic [indexWidth-1:0] cand;
      cand = indexWidth'((int'(r_ptr) + k) % width);
      if (bus.request[cand]) begin
        w_pickValid = 1'b1;
        w_pickIndex = cand;
      end
    end
  end

  assign w_grantedReq    = bus.request[r_index];
  assign w_othersPending = |(bus.request & ~r_grant);
  assign w_succIndex     = (r_index == LastIndex) ? '0 : r_index + 1'b1;

  always_comb begin
    w_nextState     = r_state;
    w_nextGrant     = r_grant;
    w_nextIndex     = r_index;
    w_nextPtr       = r_ptr;
    w_nextCnt       = r_cnt;
    w_nextPreempted = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextGrant = '0;
        w_nextIndex = '0;
        if (w_pickValid) begin
          w_nextGrant[w_pickIndex] = 1'b1;
          w_nextIndex              = w_pickIndex;
          w_nextCnt                = '0;
          w_nextState              = GRANTED;
        end
      end
      GRANTED: begin
        if (!w_grantedReq) begin
          w_nextGrant = '0;
          w_nextIndex = '0;
          w_nextPtr   = w_succIndex;
          w_nextState = GAP;
        end else if (HoldEnabled && (r_cnt == HoldLast) && w_othersPending) begin
          w_nextGrant     = '0;
          w_nextIndex     = '0;
          w_nextPtr       = w_succIndex;
          w_nextPreempted = 1'b1;
          w_nextState     = GAP;
        end else if (r_cnt != 16'hFFFF) begin
          w_nextCnt = r_cnt + 16'd1;
        end
      end
      GAP: begin
        w_nextGrant = '0;
        w_nextIndex = '0;
        w_nextState = IDLE;
      end
      default: begin
        w_nextGrant = '0;
        w_nextIndex = '0;
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_index     <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_preempted <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_grant     <= w_nextGrant;
      r_index     <= w_nextIndex;
      r_ptr       <= w_nextPtr;
      r_cnt       <= w_nextCnt;
      r_busy      <= |w_nextGrant;
      r_preempted <= w_nextPreempted;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.grantIndex = r_index;
  assign bus.busy       = r_busy;
  assign bus.preempted  = r_preempted;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized run against a cycle-level
// reference model, on one unlimited-hold instance and one instance with a hold limit of 4.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] reqVec;

  int compared;
  int mismatched;

  bus_arbiter_if #(.width(8), .indexWidth(3)) ifA ();
  bus_arbiter_if #(.width(8), .indexWidth(3)) ifB ();

  assign ifA.request = reqVec;
  assign ifB.request = reqVec;

  bus_arbiter #(.width(8), .indexWidth(3), .maxHold(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA)
  );

  bus_arbiter #(.width(8), .indexWidth(3), .maxHold(4)) dutH (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per instance, current owner (-1 = none), cycles held so far,
  // rotating start position, and remaining dead cycles before arbitration resumes.
  int mCur[2];
  int mPtr[2];
  int mCool[2];
  int mHeld[2];
  bit mPre[2];
  int mMax[2] = '{0, 4};

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      mCur[i]  = -1;
      mPtr[i]  = 0;
      mCool[i] = 0;
      mHeld[i] = 0;
      mPre[i]  = 1'b0;
    end
  endfunction

  function automatic void modelStep(logic [7:0] req);
    for (int i = 0; i < 2; i++) begin
      mPre[i] = 1'b0;
      if (mCur[i] >= 0) begin
        logic [7:0] mine;
        bit others;
        mine   = 8'(1 << mCur[i]);
        others = (req & ~mine) != 8'd0;
        if (!req[mCur[i]]) begin
          mPtr[i]  = (mCur[i] + 1) % 8;
          mCur[i]  = -1;
          mCool[i] = 1;
        end else if (mMax[i] != 0 && mHeld[i] == mMax[i] && others) begin
          mPtr[i]  = (mCur[i] + 1) % 8;
          mCur[i]  = -1;
          mCool[i] = 1;
          mPre[i]  = 1'b1;
        end else if (mHeld[i] < 65536) begin
          mHeld[i] = mHeld[i] + 1;
        end
      end else if (mCool[i] > 0) begin
        mCool[i] = mCool[i] - 1;
      end else begin
        for (int k = 0; k < 8; k++) begin
          int idx;
          idx = (mPtr[i] + k) % 8;
          if (mCur[i] < 0 && req[idx]) begin
            mCur[i]  = idx;
            mHeld[i] = 1;
          end
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) modelReset();
    else modelStep(reqVec);
    @(negedge clk);
  endtask

  task automatic applyReset();
    reset  = 1'b1;
    reqVec = 8'd0;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    compared++;
    if (ifB.preempted !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset.preempted: actual %b required 0", ifB.preempted);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      compared++;
      if (ifA.grant !== 8'd0 || ifA.busy !== 1'b0 || ifA.grantIndex !== 3'd0) begin
        mismatched++;
        $display("[TB] FAIL reset.idleA: actual grant %b busy %b index %0d required 0/0/0",
                 ifA.grant, ifA.busy, ifA.grantIndex);
      end
      compared++;
      if (ifB.grant !== 8'd0 || ifB.busy !== 1'b0 || ifB.grantIndex !== 3'd0) begin
        mismatched++;
        $display("[TB] FAIL reset.idleB: actual grant %b busy %b index %0d required 0/0/0",
                 ifB.grant, ifB.busy, ifB.grantIndex);
      end
    end
  endtask

  task automatic test_grant_release();
    logic [7:0] expGrant [4] = '{8'b0000_0010, 8'd0, 8'd0, 8'b0000_0100};
    logic [2:0] expIndex [4] = '{3'd1, 3'd0, 3'd0, 3'd2};
    applyReset();
    reqVec = 8'b0000_0110;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) reqVec = 8'b0000_0100;
      compared++;
      if (ifA.grant !== expGrant[c] || ifA.grantIndex !== expIndex[c]
          || ifA.busy !== (expGrant[c] != 8'd0)) begin
        mismatched++;
        $display("[TB] FAIL grantRelease.step%0d: actual grant %b index %0d busy %b required %b/%0d",
                 c, ifA.grant, ifA.grantIndex, ifA.busy, expGrant[c], expIndex[c]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] expGrant [7] = '{8'b0010_0000, 8'd0, 8'd0, 8'b1000_0000, 8'd0, 8'd0, 8'b0000_0001};
    logic [2:0] expIndex [7] = '{3'd5, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
    applyReset();
    reqVec = 8'b0010_0000;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) reqVec = 8'b1000_0001;
      if (c == 3) reqVec = 8'b0000_0001;
      compared++;
      if (ifA.grant !== expGrant[c] || ifA.grantIndex !== expIndex[c]) begin
        mismatched++;
        $display("[TB] FAIL wrap.step%0d: actual grant %b index %0d required %b/%0d",
                 c, ifA.grant, ifA.grantIndex, expGrant[c], expIndex[c]);
      end
    end
  endtask

  task automatic test_preempt();
    applyReset();
    reqVec = 8'b0000_1001;
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++;
      if (ifB.grant !== 8'b0000_0001 || ifB.preempted !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL preempt.hold%0d: actual grant %b preempted %b required 00000001/0",
                 c, ifB.grant, ifB.preempted);
      end
    end
    tick();
    compared++;
    if (ifB.grant !== 8'd0 || ifB.preempted !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL preempt.gap: actual grant %b preempted %b required 0/1",
               ifB.grant, ifB.preempted);
    end
    tick();
    compared++;
    if (ifB.grant !== 8'd0 || ifB.preempted !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL preempt.idle: actual grant %b preempted %b required 0/0",
               ifB.grant, ifB.preempted);
    end
    tick();
    compared++;
    if (ifB.grant !== 8'b0000_1000 || ifB.grantIndex !== 3'd3) begin
      mismatched++;
      $display("[TB] FAIL preempt.next: actual grant %b index %0d required 00001000/3",
               ifB.grant, ifB.grantIndex);
    end
    applyReset();
    reqVec = 8'b0000_0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      compared++;
      if (ifB.grant !== 8'b0000_0001 || ifB.preempted !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL preempt.solo%0d: actual grant %b preempted %b required 00000001/0",
                 c, ifB.grant, ifB.preempted);
      end
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    reqVec = 8'b0000_0100;
    tick();
    compared++;
    if (ifA.grant !== 8'b0000_0100) begin
      mismatched++;
      $display("[TB] FAIL resetMid.before: actual grant %b required 00000100", ifA.grant);
    end
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    compared++;
    if (ifA.grant !== 8'd0 || ifA.busy !== 1'b0 || ifA.grantIndex !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL resetMid.async: actual grant %b busy %b index %0d required 0/0/0",
               ifA.grant, ifA.busy, ifA.grantIndex);
    end
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    reqVec = 8'b0000_1100;
    tick();
    compared++;
    if (ifA.grant !== 8'b0000_0100 || ifA.grantIndex !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL resetMid.after: actual grant %b index %0d required 00000100/2",
               ifA.grant, ifA.grantIndex);
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    reqVec = 8'b0000_1000;
    tick();
    for (int c = 0; c < 16; c++) begin
      compared++;
      if (ifA.grant !== 8'b0000_1000 || $countones(ifA.grant) > 1) begin
        mismatched++;
        $display("[TB] FAIL backToBack.hold%0d: actual grant %b required 00001000",
                 c, ifA.grant);
      end
      reqVec = 8'($urandom) | 8'b0000_1000;
      tick();
    end
  endtask

  task automatic test_random();
    applyReset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 3) == 0) reqVec[b] = ~reqVec[b];
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        logic [7:0] g;
        logic [2:0] x;
        logic       bz;
        logic       p;
        logic [7:0] eg;
        logic [2:0] ex;
        g  = (i == 0) ? ifA.grant : ifB.grant;
        x  = (i == 0) ? ifA.grantIndex : ifB.grantIndex;
        bz = (i == 0) ? ifA.busy : ifB.busy;
        p  = (i == 0) ? ifA.preempted : ifB.preempted;
        eg = (mCur[i] >= 0) ? 8'(1 << mCur[i]) : 8'd0;
        ex = (mCur[i] >= 0) ? 3'(mCur[i]) : 3'd0;
        compared++;
        if (g !== eg || x !== ex || bz !== (eg != 8'd0) || p !== mPre[i]) begin
          mismatched++;
          $display("[TB] FAIL random.dut%0d.cycle%0d: actual %b/%0d/%b/%b required %b/%0d/%b/%b req %b",
                   i, c, g, x, bz, p, eg, ex, (eg != 8'd0), mPre[i], reqVec);
        end
        compared++;
        if ($countones(g) > 1) begin
          mismatched++;
          $display("[TB] FAIL random.oneHot%0d: actual grant %b required at most one bit", i, g);
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    reqVec     = 8'd0;
    test_reset();
    test_grant_release();
    test_wrap();
    test_preempt();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
